// File: rtl/rb_fifo_port_scheduler.sv
// Round-robin push arbiter and push/pop sequencer in front of one ring-buffer FIFO.
// Push and pop are never issued together; contested cycles alternate between them.
module rb_fifo_port_scheduler #(
  parameter int NREQ  = 4,
  parameter int MSBD  = 3,
  parameter int DEPTH = 16,
  parameter int CW    = 5
) (
  input  logic                     clock,
  input  logic                     rst,
  input  logic [NREQ-1:0]          i_req,
  input  logic [NREQ*(MSBD+1)-1:0] i_req_data,
  output logic [NREQ-1:0]          o_ack,
  input  logic                     i_pop_req,
  output logic                     o_pop_ack,
  output logic                     o_fifo_push,
  output logic                     o_fifo_pop,
  output logic [MSBD:0]            o_fifo_din,
  input  logic                     i_fifo_full,
  input  logic                     i_fifo_empty,
  output logic [2:0]               o_grant_id,
  output logic [CW-1:0]            o_occupancy
);

  localparam int W = MSBD + 1;

  if (NREQ < 2 || NREQ > 8 || (1 << CW) <= DEPTH) begin : g_bad_param
    $error("rb_fifo_port_scheduler: bad parameters");
  end

  logic [2:0]    r_rr;
  logic          r_fav;
  logic [CW-1:0] r_occ;

  logic [2:0]    w_win;
  logic [MSBD:0] w_din;
  logic [2:0]    w_rr_nxt;
  logic          w_push_ok;
  logic          w_pop_ok;
  logic          w_do_push;
  logic          w_do_pop;

  // Winner is the requester at the smallest rotated distance from r_rr.
  always_comb begin : pick
    int best;
    int d;
    w_win = '0;
    w_din = '0;
    best  = NREQ;
    d     = 0;
    for (int i = 0; i < NREQ; i++) begin
      if (i >= int'(r_rr)) d = i - int'(r_rr);
      else d = i + NREQ - int'(r_rr);
      if (i_req[i] && d < best) begin
        best  = d;
        w_win = 3'(i);
        w_din = i_req_data[i*W +: W];
      end
    end
  end

  assign w_push_ok = (|i_req) & ~i_fifo_full;
  assign w_pop_ok  = i_pop_req & ~i_fifo_empty;
  assign w_do_pop  = ~rst & w_pop_ok & (~w_push_ok | r_fav);
  assign w_do_push = ~rst & w_push_ok & ~(w_pop_ok & r_fav);

  assign w_rr_nxt = (w_win == 3'(NREQ - 1)) ? 3'd0 : w_win + 3'd1;

  assign o_fifo_push = w_do_push;
  assign o_fifo_pop  = w_do_pop;
  assign o_pop_ack   = w_do_pop;
  assign o_fifo_din  = w_din;
  assign o_grant_id  = w_win;
  assign o_occupancy = r_occ;
  assign o_ack = w_do_push ? (NREQ'(1) << w_win) : '0;

  always_ff @(posedge clock) begin
    if (rst) begin
      r_rr  <= '0;
      r_fav <= 1'b0;
      r_occ <= '0;
    end else begin
      if (w_do_push) begin
        r_rr  <= w_rr_nxt;
        r_occ <= r_occ + CW'(1);
      end else if (w_do_pop) begin
        r_occ <= r_occ - CW'(1);
      end
      if (w_push_ok & w_pop_ok) r_fav <= w_do_push;
    end
  end

endmodule

// File: tb/tb_rb_fifo_port_scheduler.sv
// Bench for rb_fifo_port_scheduler: queue FIFO, queue-based reference model,
// directed scenarios then randomized traffic.
module tb_rb_fifo_port_scheduler;

  localparam int NREQ = 4;
  localparam int DEP  = 16;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [3:0]  pd [4];
  logic [15:0] req_data;
  logic [3:0]  ack;
  logic        pop_req = 1'b0;
  logic        pop_ack;
  logic        f_push;
  logic        f_pop;
  logic [3:0]  f_din;
  logic        fifo_full = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [3:0]  fifo_dout = '0;
  logic [2:0]  grant;
  logic [4:0]  occ;

  assign req_data = {pd[3], pd[2], pd[1], pd[0]};

  rb_fifo_port_scheduler #(.NREQ(4), .MSBD(3), .DEPTH(16), .CW(5)) dut (
    .clock        (clock),
    .rst          (rst),
    .i_req        (req),
    .i_req_data   (req_data),
    .o_ack        (ack),
    .i_pop_req    (pop_req),
    .o_pop_ack    (pop_ack),
    .o_fifo_push  (f_push),
    .o_fifo_pop   (f_pop),
    .o_fifo_din   (f_din),
    .i_fifo_full  (fifo_full),
    .i_fifo_empty (fifo_empty),
    .o_grant_id   (grant),
    .o_occupancy  (occ)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model state
  int         m_rr = 0;
  bit         m_fav = 0;
  int         m_occ = 0;
  logic [3:0] mq[$];
  logic [3:0] fq[$];

  bit         e_push, e_pop, m_conf;
  int         e_win;
  logic [3:0] e_din;
  bit         c_push, c_pop;
  logic [3:0] c_din;
  logic [3:0] ack_cap = '0;

  always @(negedge clock) begin
    bit pok, qok;
    int idx;
    e_push = 0; e_pop = 0; e_win = 0; e_din = '0; m_conf = 0;
    if (!rst) begin
      pok = (|req) && (fq.size() < DEP);
      qok = pop_req && (fq.size() > 0);
      m_conf = pok && qok;
      if (pok && qok) begin
        if (m_fav) e_pop = 1; else e_push = 1;
      end else if (pok) e_push = 1;
      else if (qok) e_pop = 1;
      if (e_push) begin
        for (int k = 0; k < NREQ; k++) begin
          idx = (m_rr + k) % NREQ;
          if (req[idx]) begin
            e_win = idx;
            break;
          end
        end
        e_din = pd[e_win];
      end
    end
    chk("fifo_push", f_push, e_push);
    chk("fifo_pop", f_pop, e_pop);
    chk("pop_ack", pop_ack, e_pop);
    chk("ack", ack, e_push ? (4'b1 << e_win) : 4'b0);
    chk("occupancy", occ, m_occ);
    if (e_push) begin
      chk("grant_id", grant, e_win);
      chk("fifo_din", f_din, e_din);
    end
    if (e_pop && pop_ack && fq.size() > 0 && mq.size() > 0)
      chk("pop_data", fq[0], mq[0]);
    c_push = f_push;
    c_pop = f_pop;
    c_din = f_din;
    ack_cap = ack;
  end

  always @(posedge clock) begin
    if (rst) begin
      m_rr = 0; m_fav = 0; m_occ = 0;
      mq.delete();
      fq.delete();
    end else begin
      if (e_push) begin
        m_rr = (e_win + 1) % NREQ;
        m_occ++;
        mq.push_back(e_din);
      end else if (e_pop) begin
        m_occ--;
        if (mq.size() > 0) void'(mq.pop_front());
      end
      if (m_conf) m_fav = e_push;
      if (c_push) begin
        if (fq.size() < DEP) fq.push_back(c_din);
      end else if (c_pop) begin
        if (fq.size() > 0) void'(fq.pop_front());
      end
    end
    fifo_full = (fq.size() == DEP);
    fifo_empty = (fq.size() == 0);
    fifo_dout = (fq.size() > 0) ? fq[0] : 4'h0;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    pd[0] = 4'h1; pd[1] = 4'h2; pd[2] = 4'h3; pd[3] = 4'h4;
    // reset with everything requesting
    rst = 1'b1; req = 4'b1111; pop_req = 1'b1;
    step(); step();
    #1;
    chk("rst_ack", ack, 4'b0);
    chk("rst_pop_ack", pop_ack, 1'b0);
    chk("rst_push", f_push, 1'b0);
    chk("rst_pop", f_pop, 1'b0);
    rst = 1'b0; req = '0; pop_req = 1'b0;
    step();
    #1;
    chk("rst_occ", occ, 5'd0);

    // round robin until full
    req = 4'b1111;
    for (int k = 0; k < 16; k++) begin
      #1;
      if (k < 5) begin
        chk("rr_ack", ack, 4'b1 << (k % 4));
        chk("rr_din", f_din, 4'((k % 4) + 1));
      end
      step();
    end
    #1;
    chk("full_occ", occ, 5'd16);
    chk("full_flag", fifo_full, 1'b1);
    chk("full_no_ack", ack, 4'b0);
    pop_req = 1'b1;
    #1;
    chk("full_pop_ack", pop_ack, 1'b1);
    chk("full_pop_no_ack", ack, 4'b0);
    step();
    pop_req = 1'b0;
    #1;
    chk("after_pop_ack", ack, 4'b0001);
    step();
    req = '0;

    // drain, then empty behaviour
    pop_req = 1'b1;
    for (int k = 0; k < 16; k++) step();
    #1;
    chk("empty_pop_ack", pop_ack, 1'b0);
    chk("empty_occ", occ, 5'd0);
    pop_req = 1'b0;
    pd[0] = 4'hA; req = 4'b0001;
    #1;
    chk("emp_push_ack", ack, 4'b0001);
    step();
    req = '0;
    #1;
    chk("emp_occ1", occ, 5'd1);
    pop_req = 1'b1;
    #1;
    chk("emp_pop_ack", pop_ack, 1'b1);
    chk("emp_dout", fifo_dout, 4'hA);
    step();
    pop_req = 1'b0;
    #1;
    chk("emp_occ0", occ, 5'd0);

    // conflict alternation at occ=3
    pd[1] = 4'h5; req = 4'b0010;
    step(); step(); step();
    pd[2] = 4'h7; req = 4'b0100; pop_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("cf_push", f_push, (k % 2) == 0);
      chk("cf_pop", f_pop, (k % 2) == 1);
      chk("cf_occ", occ, (k % 2) ? 5'd4 : 5'd3);
      step();
    end
    pop_req = 1'b0;

    // reset in the middle of traffic at occ=5
    pd[0] = 4'h9; req = 4'b0001;
    step(); step();
    #1;
    chk("mid_occ5", occ, 5'd5);
    req = 4'b0110; rst = 1'b1;
    #1;
    chk("mid_rst_ack", ack, 4'b0);
    chk("mid_rst_push", f_push, 1'b0);
    step();
    rst = 1'b0;
    #1;
    chk("mid_occ0", occ, 5'd0);
    chk("mid_ack", ack, 4'b0010);
    chk("mid_grant", grant, 3'd1);
    step();
    req = '0;

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && ack_cap[i]) req[i] = 1'b0;
        else if (req[i] && $urandom_range(19) == 0) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(2) == 0) begin
          req[i] = 1'b1;
          pd[i] = 4'($urandom);
        end
      end
      if (((c / 250) % 2) == 0) pop_req = ($urandom_range(7) == 0);
      else pop_req = ($urandom_range(3) != 0);
      rst = ($urandom_range(499) == 0);
    end
    rst = 1'b0; req = '0; pop_req = 1'b0;
    step(); step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
